// File: rtl/sdram_init_checker_pkg.sv
// Shared SDRAM definitions for the init checker and the initializer.
// Contents: command encodings, timing defaults, error codes, the checker
// state type, the decoded-command payload and a saturating increment helper.
package sdram_init_checker_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned REF_W  = 8;

    // Command encodings as {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_REFRESH   = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MODE_REG  = 4'b0000;

    // Timing defaults in clocks
    localparam int unsigned T_RP_DEF  = 2;
    localparam int unsigned T_RC_DEF  = 7;
    localparam int unsigned T_MRD_DEF = 2;

    // Violation codes; 0 means no violation
    localparam logic [ERR_W-1:0] ERR_NONE        = 4'd0;
    localparam logic [ERR_W-1:0] ERR_EARLY_CMD   = 4'd1;
    localparam logic [ERR_W-1:0] ERR_BAD_SEQ     = 4'd2;
    localparam logic [ERR_W-1:0] ERR_PRE_NOT_ALL = 4'd3;
    localparam logic [ERR_W-1:0] ERR_T_RP        = 4'd4;
    localparam logic [ERR_W-1:0] ERR_T_RC        = 4'd5;
    localparam logic [ERR_W-1:0] ERR_REF_COUNT   = 4'd6;
    localparam logic [ERR_W-1:0] ERR_T_MRD       = 4'd7;
    localparam logic [ERR_W-1:0] ERR_BAD_MRS     = 4'd8;

    typedef enum logic [2:0] {
        ST_POWER_WAIT = 3'd0,
        ST_WAIT_REF   = 3'd1,
        ST_REFRESHING = 3'd2,
        ST_MRD        = 3'd3,
        ST_READY      = 3'd4,
        ST_ERROR      = 3'd5
    } state_t;

    // One-hot classification of a sampled command
    typedef struct packed {
        logic is_nop;
        logic is_pre;
        logic is_ref;
        logic is_mrs;
        logic is_other;
    } cmd_dec_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational SDRAM command classifier.
// Ports: cmd   - {CS_N, RAS_N, CAS_N, WE_N} as sampled from the pins
//        dec_c - one-hot classification (deselect counts as NOP)
module sdram_cmd_decode
    import sdram_init_checker_pkg::*;
(
    input  logic [CMD_W-1:0] cmd,
    output cmd_dec_t         dec_c
);

    always_comb begin
        dec_c = '0;
        if (cmd[3]) begin
            dec_c.is_nop = 1'b1;
        end else begin
            case (cmd)
                CMD_NOP:       dec_c.is_nop   = 1'b1;
                CMD_PRECHARGE: dec_c.is_pre   = 1'b1;
                CMD_REFRESH:   dec_c.is_ref   = 1'b1;
                CMD_MODE_REG:  dec_c.is_mrs   = 1'b1;
                default:       dec_c.is_other = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_checker.sv
// Passive checker for the SDRAM power-up initialization sequence.
// Watches the command pins and enforces: power-on wait, PRECHARGE ALL,
// N AUTO REFRESH, LOAD MODE REGISTER, tMRD. Latches the first violation.
// Ports: clk, reset_n (async active-low)
//        DRAM_ADDR/DRAM_BA/DRAM_CS_N/RAS_N/CAS_N/WE_N - monitored bus
//        init_done - sequence completed legally (sticky)
//        error/err_code - first violation flag and code (sticky)
//        mode_reg - address word captured at LOAD MODE REGISTER
//        ref_seen - REFRESH count during init, saturating at 255
module sdram_init_checker
    import sdram_init_checker_pkg::*;
#(
    parameter int unsigned WAIT_INIT_CYCLE    = 20000,
    parameter int unsigned AUTO_REFRESH_TIMES = 8,
    parameter int unsigned T_RP               = T_RP_DEF,
    parameter int unsigned T_RC               = T_RC_DEF,
    parameter int unsigned T_MRD              = T_MRD_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] DRAM_ADDR,
    input  logic [BA_W-1:0]   DRAM_BA,
    input  logic              DRAM_CS_N,
    input  logic              DRAM_RAS_N,
    input  logic              DRAM_CAS_N,
    input  logic              DRAM_WE_N,
    output logic              init_done,
    output logic              error,
    output logic [ERR_W-1:0]  err_code,
    output logic [ADDR_W-1:0] mode_reg,
    output logic [REF_W-1:0]  ref_seen
);

    cmd_dec_t          dec_c;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pwr_cnt, gap_cnt;
    logic [ERR_W-1:0]  err_nxt;
    logic [REF_W-1:0]  ref_nxt;
    logic [ADDR_W-1:0] mode_nxt;

    logic pwr_early_c, rp_short_c, rc_short_c, mrd_short_c, ref_few_c, mrs_bad_c;

    sdram_cmd_decode u_decode (
        .cmd   ({DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}),
        .dec_c (dec_c)
    );

    // Clocks since reset release and since the last non-NOP command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwr_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            pwr_cnt <= sat_inc(pwr_cnt);
            gap_cnt <= dec_c.is_nop ? sat_inc(gap_cnt) : CNT_W'(1);
        end
    end

    // Qualifier terms evaluated against the command being sampled
    always_comb begin
        pwr_early_c = pwr_cnt < CNT_W'(WAIT_INIT_CYCLE);
        rp_short_c  = gap_cnt < CNT_W'(T_RP);
        rc_short_c  = gap_cnt < CNT_W'(T_RC);
        mrd_short_c = gap_cnt < CNT_W'(T_MRD);
        ref_few_c   = CNT_W'(ref_seen) < CNT_W'(AUTO_REFRESH_TIMES);
        mrs_bad_c   = (DRAM_BA != '0) || (DRAM_ADDR[12:10] != 3'b000);
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_POWER_WAIT;
            init_done <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            mode_reg  <= '0;
            ref_seen  <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == ST_READY);
            error     <= (state_nxt == ST_ERROR);
            err_code  <= err_nxt;
            mode_reg  <= mode_nxt;
            ref_seen  <= ref_nxt;
        end
    end

    // Next-state logic; checks ordered timing, count, encoding, sequence
    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        ref_nxt   = ref_seen;
        mode_nxt  = mode_reg;

        case (state)
            ST_POWER_WAIT: begin
                if (!dec_c.is_nop) begin
                    state_nxt = ST_ERROR;
                    if (pwr_early_c) begin
                        err_nxt = ERR_EARLY_CMD;
                    end else if (dec_c.is_pre) begin
                        if (DRAM_ADDR[10]) begin
                            state_nxt = ST_WAIT_REF;
                        end else begin
                            err_nxt = ERR_PRE_NOT_ALL;
                        end
                    end else begin
                        err_nxt = ERR_BAD_SEQ;
                    end
                end
            end

            ST_WAIT_REF: begin
                if (dec_c.is_ref) begin
                    if (rp_short_c) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = ERR_T_RP;
                    end else begin
                        state_nxt = ST_REFRESHING;
                        ref_nxt   = REF_W'(1);
                    end
                end else if (!dec_c.is_nop) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = ERR_BAD_SEQ;
                end
            end

            ST_REFRESHING: begin
                if ((dec_c.is_ref || dec_c.is_mrs) && rc_short_c) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = ERR_T_RC;
                end else if (dec_c.is_ref) begin
                    if (ref_seen != '1) begin
                        ref_nxt = ref_seen + REF_W'(1);
                    end
                end else if (dec_c.is_mrs) begin
                    if (ref_few_c) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = ERR_REF_COUNT;
                    end else if (mrs_bad_c) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = ERR_BAD_MRS;
                    end else begin
                        state_nxt = ST_MRD;
                        mode_nxt  = DRAM_ADDR;
                    end
                end else if (!dec_c.is_nop) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = ERR_BAD_SEQ;
                end
            end

            // Completes on elapsed time alone; a command here only matters if early
            ST_MRD: begin
                if (!dec_c.is_nop && mrd_short_c) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = ERR_T_MRD;
                end else if (!mrd_short_c) begin
                    state_nxt = ST_READY;
                end
            end

            ST_READY: state_nxt = ST_READY;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_POWER_WAIT;
        endcase
    end

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker with a shortened power-on wait.
module tb_sdram_init_checker;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_ACT = 4'b0011;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] dram_addr = '0;
    logic [1:0]  dram_ba = '0;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic        init_done, error;
    logic [3:0]  err_code;
    logic [12:0] mode_reg;
    logic [7:0]  ref_seen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_init_checker #(
        .WAIT_INIT_CYCLE    (20),
        .AUTO_REFRESH_TIMES (8),
        .T_RP               (2),
        .T_RC               (7),
        .T_MRD              (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .DRAM_ADDR  (dram_addr),
        .DRAM_BA    (dram_ba),
        .DRAM_CS_N  (cs_n),
        .DRAM_RAS_N (ras_n),
        .DRAM_CAS_N (cas_n),
        .DRAM_WE_N  (we_n),
        .init_done  (init_done),
        .error      (error),
        .err_code   (err_code),
        .mode_reg   (mode_reg),
        .ref_seen   (ref_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given command, then return to NOP; ends #1 after the edge
    task automatic cyc(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b);
        {cs_n, ras_n, cas_n, we_n} = c;
        dram_addr = a;
        dram_ba   = b;
        @(posedge clk);
        #1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        dram_addr = '0;
        dram_ba   = '0;
    endtask

    task automatic cmd(input logic [3:0] c);
        cyc(c, 13'h000, 2'b00);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP);
    endtask

    // Reset, verify cleared outputs, release so the next edge has pwr_cnt 0
    task automatic do_reset();
        reset_n = 1'b0;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_error",     32'(error),     32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        chk("rst_mode_reg",  32'(mode_reg),  32'd0);
        chk("rst_ref_seen",  32'(ref_seen),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Legal prefix: PRE ALL at pwr_cnt 20, REF at tRP, then REFs every 7
    task automatic prep(input int nref);
        do_reset();
        nops(20);
        cyc(C_PRE, 13'h400, 2'b00);
        nops(1);
        cmd(C_REF);
        for (int i = 1; i < nref; i++) begin
            nops(6);
            cmd(C_REF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Legal sequence
        prep(8);
        chk("legal_ref_seen", 32'(ref_seen), 32'd8);
        chk("legal_no_err",   32'(error),    32'd0);
        nops(6);
        cyc(C_MRS, 13'h021, 2'b00);
        chk("legal_mode_reg", 32'(mode_reg),  32'h021);
        chk("legal_not_done0", 32'(init_done), 32'd0);
        nops(1);
        chk("legal_not_done1", 32'(init_done), 32'd0);
        nops(1);
        chk("legal_done",     32'(init_done), 32'd1);
        chk("legal_err0",     32'(error),     32'd0);
        cmd(C_REF);
        chk("ready_sticky",   32'(init_done), 32'd1);
        chk("ready_ref_frz",  32'(ref_seen),  32'd8);
        chk("ready_no_err",   32'(error),     32'd0);

        // Early command, then legal traffic must not change the code
        do_reset();
        nops(5);
        cmd(C_REF);
        chk("early_err",      32'(error),    32'd1);
        chk("early_code",     32'(err_code), 32'd1);
        nops(20);
        cyc(C_PRE, 13'h400, 2'b00);
        chk("early_sticky",   32'(err_code), 32'd1);
        chk("early_no_done",  32'(init_done), 32'd0);

        // PRE one clock before the wait limit
        do_reset();
        nops(19);
        cyc(C_PRE, 13'h400, 2'b00);
        chk("pre_at_19",      32'(err_code), 32'd1);

        // PRE without A10
        do_reset();
        nops(25);
        cyc(C_PRE, 13'h000, 2'b00);
        chk("pre_not_all",    32'(err_code), 32'd3);
        chk("pre_not_all_e",  32'(error),    32'd1);

        // Wrong first command after the wait
        do_reset();
        nops(20);
        cmd(C_REF);
        chk("pw_bad_seq",     32'(err_code), 32'd2);

        // REFRESH one clock after PRE
        do_reset();
        nops(20);
        cyc(C_PRE, 13'h400, 2'b00);
        cmd(C_REF);
        chk("trp_short",      32'(err_code), 32'd4);

        // MRS directly after PRE
        do_reset();
        nops(20);
        cyc(C_PRE, 13'h400, 2'b00);
        nops(3);
        cyc(C_MRS, 13'h021, 2'b00);
        chk("wr_bad_seq",     32'(err_code), 32'd2);

        // REFRESH spacing 6 vs 7
        prep(1);
        nops(5);
        cmd(C_REF);
        chk("trc_6",          32'(err_code), 32'd5);
        prep(1);
        nops(6);
        cmd(C_REF);
        chk("trc_7_no_err",   32'(error),    32'd0);
        chk("trc_7_ref",      32'(ref_seen), 32'd2);

        // Too few refreshes
        prep(7);
        nops(6);
        cyc(C_MRS, 13'h021, 2'b00);
        chk("few_ref_code",   32'(err_code), 32'd6);
        chk("few_ref_mode",   32'(mode_reg), 32'd0);
        chk("few_ref_done",   32'(init_done), 32'd0);

        // Timing outranks count
        prep(7);
        nops(5);
        cyc(C_MRS, 13'h021, 2'b00);
        chk("prio_trc",       32'(err_code), 32'd5);

        // Nonzero bank on MRS
        prep(8);
        nops(6);
        cyc(C_MRS, 13'h021, 2'b01);
        chk("bad_mrs_ba",     32'(err_code), 32'd8);

        // Reserved mode bits set
        prep(8);
        nops(6);
        cyc(C_MRS, 13'h421, 2'b00);
        chk("bad_mrs_a10",    32'(err_code), 32'd8);

        // Command inside tMRD
        prep(8);
        nops(6);
        cyc(C_MRS, 13'h021, 2'b00);
        cmd(C_ACT);
        chk("tmrd_short",     32'(err_code), 32'd7);
        chk("tmrd_mode_kept", 32'(mode_reg), 32'h021);

        // Command exactly at tMRD is legal
        prep(8);
        nops(6);
        cyc(C_MRS, 13'h033, 2'b00);
        nops(1);
        cmd(C_ACT);
        chk("tmrd_exact",     32'(init_done), 32'd1);
        chk("tmrd_exact_e",   32'(error),     32'd0);

        // Asynchronous reset mid-sequence, then full rerun
        prep(4);
        chk("mid_ref4",       32'(ref_seen), 32'd4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ref",    32'(ref_seen), 32'd0);
        chk("mid_rst_err",    32'(error),    32'd0);
        prep(8);
        nops(6);
        cyc(C_MRS, 13'h021, 2'b00);
        nops(2);
        chk("mid_rerun_done", 32'(init_done), 32'd1);
        chk("mid_rerun_ref",  32'(ref_seen),  32'd8);
        chk("mid_rerun_mode", 32'(mode_reg),  32'h021);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
